lsu_dmem_ctrl: RTL
==================

# lsu_dmem_ctrl

Load/store unit on the CPU side of the data-memory port: the initiator counterpart to the word-addressed data memory. It accepts RV32I load/store requests from the datapath and drives the memory's read/write strobes, word address and write data. Sub-word loads are extracted and sign- or zero-extended. Sub-word stores run as a read-modify-write sequence, because the memory only writes whole words. The CPU is stalled through `busy` while a request is in flight.

## Interface
- `DEPTH_LOG2`, default 6: log2 of the data-memory depth in words. The word index is `req_addr[DEPTH_LOG2+1:2]`; upper address bits are ignored, so addresses wrap modulo the memory size.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-low reset.
- `req_valid` in 1: CPU presents a request this cycle.
- `req_write` in 1: 1 = store, 0 = load.
- `req_funct3` in 3: RV32I funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU).
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, taken from the low bits for B/H.
- `busy` out 1: request in flight; the CPU must stall.
- `resp_valid` out 1: one-cycle completion pulse.
- `resp_rdata` out 32: load result, valid while `resp_valid` is high; 0 for stores and errors.
- `err` out 1: qualifies `resp_valid`; set for misalignment or an illegal funct3.
- `mem_address` out 32: word index, zero-extended.
- `mem_read` out 1: memory read enable.
- `mem_write` out 1: memory write enable.
- `mem_wdata` out 32: word written to memory.
- `mem_rdata` in 32: combinational read data from memory.

## Operation
- **FSM states:** IDLE, ACCESS, WRITE, RESP.
- **Accept:** in IDLE with `req_valid`=1, the block latches addr, wdata, funct3 and write.
  - If the request is illegal, go to RESP with `err`=1.
  - Otherwise go to ACCESS.
- **Illegal requests:** funct3 ∈ {011, 110, 111}; a store with funct3 ∈ {100, 101}; H with `addr[0]`=1; W with `addr[1:0]`≠0.
- **ACCESS outputs:** `mem_address` = latched word index.
  - SW: `mem_write`=1, `mem_wdata`=wdata, next state RESP.
  - Loads and SB/SH: `mem_read`=1. `mem_rdata` is sampled at the end of the cycle.
  - Load: `resp_rdata` is registered from the extracted lane, then RESP.
    - Byte lane = `addr[1:0]`; half lane = `addr[1]`.
    - B/H sign-extend; BU/HU zero-extend.
  - SB/SH: the merged word is registered, then WRITE.
    - Merge = the read word with the addressed byte replaced by `wdata[7:0]`, or the addressed half replaced by `wdata[15:0]`.
- **WRITE outputs:** `mem_write`=1, `mem_wdata`=merged word, same `mem_address`. Next state RESP.
- **RESP:** `resp_valid`=1 for one cycle, then IDLE.
- **Outside ACCESS/WRITE:** `mem_read`, `mem_write`, `mem_address` and `mem_wdata` are all 0.
- **`busy`:** `busy` = (state≠IDLE). `req_valid` is ignored while busy. A new request may be accepted in the cycle after RESP.
- **`mem_write` gating:** `mem_write` is gated by `rst`. With `rst`=0 no memory write is issued, even in ACCESS or WRITE.

## Timing
- **Reset:** `rst`=0 sampled at an edge returns the block to IDLE and clears all registers. All outputs read 0, including `busy`, `resp_valid`, `resp_rdata` and `err`.
- **Reset mid-operation:** the operation is aborted. No partial RMW write occurs and no `resp_valid` is produced.
- **Latency,** request accepted at edge 0:
  - LW/LB/LH/LBU/LHU/SW: ACCESS in cycle 1, `resp_valid` in cycle 2.
  - SB/SH: read in cycle 1, write in cycle 2, `resp_valid` in cycle 3.
  - Error: `resp_valid` with `err`=1 in cycle 1; no memory strobe is issued.
- **Output registration:** `resp_*`, `err` and `busy` are registered. `mem_*` outputs are decoded from state and latched values only, with no combinational path from the `req_*` inputs.
- **Back-to-back:** `req_valid` held high continuously gives one accepted request per completed response.

## Test plan
- **Reset:** hold `rst`=0 for 2 cycles while `req_valid`=1 → all outputs 0; no `mem_write` is issued.
- **Store/load word:** SW 0xDEADBEEF to addr 0x10, then LW 0x10 → `mem_address`=4; memory word 4 = 0xDEADBEEF; `resp_rdata`=0xDEADBEEF 2 cycles after accept.
- **Byte store and loads,** memory word 4 preloaded with 0x11223344:
  - SB 0xAB to addr 0x12 → word becomes 0x11AB3344; `resp_valid` in cycle 3.
  - LB from 0x12 → 0xFFFFFFAB.
  - LBU from 0x12 → 0x000000AB.
- **Half-word,** word 4 preloaded with 0x11AB3344:
  - SH 0x8001 to addr 0x12 → word becomes 0x80013344.
  - LH from 0x12 → 0xFFFF8001.
  - LHU from 0x12 → 0x00008001.
- **Errors:** LW at 0x13, SH at 0x11, funct3=011 → `resp_valid`=1 and `err`=1 one cycle after accept; `mem_read`/`mem_write` never asserted; memory unchanged.
- **Abort and stall:** assert `rst`=0 during the WRITE cycle of an SB → memory word unchanged and no `resp_valid`. Separately, pulse a second `req_valid` while `busy`=1 → the second request is ignored.

Source files
------------

// File: rtl/lsu_dmem_if.sv
// Bundle of the CPU request/response signals and the data-memory port
// that surround the load/store unit.
//
// Handshake: the CPU raises req_valid with a stable request while busy is
// low; the request is taken on that rising edge and busy stays high until
// the response completes. resp_valid is a one-cycle pulse, and err and
// resp_rdata are meaningful only while it is high. req_valid is ignored
// while busy is high. The memory side has no handshake: mem_rdata is
// combinational from mem_address, and a write happens on any edge where
// mem_write is high.
interface lsu_dmem_if;
    logic        req_valid;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        busy;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        err;
    logic [31:0] mem_address;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic [1:0]  dbg_state;

    // Load/store unit view
    modport slave (
        input  req_valid, req_write, req_funct3, req_addr, req_wdata, mem_rdata,
        output busy, resp_valid, resp_rdata, err,
        output mem_address, mem_read, mem_write, mem_wdata, dbg_state
    );

    // Environment view: CPU plus data memory
    modport master (
        output req_valid, req_write, req_funct3, req_addr, req_wdata, mem_rdata,
        input  busy, resp_valid, resp_rdata, err,
        input  mem_address, mem_read, mem_write, mem_wdata, dbg_state
    );
endinterface

// File: rtl/lsu_dmem_ctrl.sv
// RV32I load/store unit in front of a word-addressed data memory.
// Sub-word loads are extracted and extended. Sub-word stores use a
// read-modify-write sequence because the memory writes whole words only.
// dbg_state shows the FSM state: 0 IDLE, 1 ACCESS, 2 WRITE, 3 RESP.
module lsu_dmem_ctrl #(
    parameter int DEPTH_LOG2 = 6
) (
    input  logic        clk,
    input  logic        rst,
    lsu_dmem_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, WRITE, RESP} state_t;

    state_t                state;
    logic [DEPTH_LOG2-1:0] word_q;
    logic [1:0]            off_q;
    logic [31:0]           wdata_q;
    logic [31:0]           merged_q;
    logic [2:0]            funct3_q;
    logic                  write_q;

    logic [31:0] load_data;
    logic [31:0] merge_data;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic        is_sw;
    logic        req_illegal;

    // Address bits above the word index are dropped, so addresses wrap.
    logic unused_addr_hi;
    assign unused_addr_hi = ^bus.req_addr[31:DEPTH_LOG2+2];

    assign is_sw         = write_q && (funct3_q == 3'b010);
    assign bus.dbg_state = state;

    // Legality of the incoming request, checked only at accept
    always_comb begin
        req_illegal = 1'b0;
        case (bus.req_funct3)
            3'b000:  req_illegal = 1'b0;
            3'b001:  req_illegal = bus.req_addr[0];
            3'b010:  req_illegal = (bus.req_addr[1:0] != 2'b00);
            3'b100,
            3'b101:  req_illegal = bus.req_write;
            default: req_illegal = 1'b1;
        endcase
    end

    // Lane extraction for loads and lane merge for sub-word stores
    always_comb begin
        byte_sel = 8'h00;
        case (off_q)
            2'd0:    byte_sel = bus.mem_rdata[7:0];
            2'd1:    byte_sel = bus.mem_rdata[15:8];
            2'd2:    byte_sel = bus.mem_rdata[23:16];
            default: byte_sel = bus.mem_rdata[31:24];
        endcase
        half_sel = off_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];

        load_data = bus.mem_rdata;
        case (funct3_q)
            3'b000:  load_data = {{24{byte_sel[7]}}, byte_sel};
            3'b100:  load_data = {24'h000000, byte_sel};
            3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
            3'b101:  load_data = {16'h0000, half_sel};
            default: load_data = bus.mem_rdata;
        endcase

        merge_data = bus.mem_rdata;
        if (funct3_q[0]) begin
            if (off_q[1]) merge_data[31:16] = wdata_q[15:0];
            else          merge_data[15:0]  = wdata_q[15:0];
        end else begin
            case (off_q)
                2'd0:    merge_data[7:0]   = wdata_q[7:0];
                2'd1:    merge_data[15:8]  = wdata_q[7:0];
                2'd2:    merge_data[23:16] = wdata_q[7:0];
                default: merge_data[31:24] = wdata_q[7:0];
            endcase
        end
    end

    // Memory strobes decoded from state and latched request only; the write
    // strobe is also gated by reset so an aborted RMW never lands.
    always_comb begin
        bus.mem_address = 32'h0;
        bus.mem_read    = 1'b0;
        bus.mem_write   = 1'b0;
        bus.mem_wdata   = 32'h0;
        case (state)
            ACCESS: begin
                bus.mem_address = {{(32-DEPTH_LOG2){1'b0}}, word_q};
                if (is_sw) begin
                    bus.mem_write = rst;
                    bus.mem_wdata = wdata_q;
                end else begin
                    bus.mem_read = 1'b1;
                end
            end
            WRITE: begin
                bus.mem_address = {{(32-DEPTH_LOG2){1'b0}}, word_q};
                bus.mem_write   = rst;
                bus.mem_wdata   = merged_q;
            end
            default: ;
        endcase
    end

    // Control FSM with registered busy and response outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            state          <= IDLE;
            word_q         <= '0;
            off_q          <= 2'b00;
            wdata_q        <= 32'h0;
            merged_q       <= 32'h0;
            funct3_q       <= 3'b000;
            write_q        <= 1'b0;
            bus.busy       <= 1'b0;
            bus.resp_valid <= 1'b0;
            bus.resp_rdata <= 32'h0;
            bus.err        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        word_q         <= bus.req_addr[DEPTH_LOG2+1:2];
                        off_q          <= bus.req_addr[1:0];
                        wdata_q        <= bus.req_wdata;
                        funct3_q       <= bus.req_funct3;
                        write_q        <= bus.req_write;
                        bus.busy       <= 1'b1;
                        bus.resp_rdata <= 32'h0;
                        if (req_illegal) begin
                            state          <= RESP;
                            bus.resp_valid <= 1'b1;
                            bus.err        <= 1'b1;
                        end else begin
                            state <= ACCESS;
                        end
                    end
                end
                ACCESS: begin
                    if (!write_q) begin
                        bus.resp_rdata <= load_data;
                        bus.resp_valid <= 1'b1;
                        state          <= RESP;
                    end else if (is_sw) begin
                        bus.resp_valid <= 1'b1;
                        state          <= RESP;
                    end else begin
                        merged_q <= merge_data;
                        state    <= WRITE;
                    end
                end
                WRITE: begin
                    bus.resp_valid <= 1'b1;
                    state          <= RESP;
                end
                default: begin
                    bus.resp_valid <= 1'b0;
                    bus.err        <= 1'b0;
                    bus.resp_rdata <= 32'h0;
                    bus.busy       <= 1'b0;
                    state          <= IDLE;
                end
            endcase
        end
    end
endmodule
